// File: rtl/cell_exerciser_pkg.sv
// Shared types and constants for the standard-cell exerciser.
package cell_exerciser_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRIVE  = 3'd1,
    WAIT   = 3'd2,
    SAMPLE = 3'd3,
    DONE   = 3'd4
  } state_e;

  localparam logic [7:0] ERR_MAX = 8'd255;

  // Number of input vectors for an n-input cell.
  function automatic int unsigned vec_count(input int unsigned n);
    return 32'd1 << n;
  endfunction

endpackage

// File: rtl/cell_exerciser_resp_sync.sv
// Two-flop synchroniser for the cell response.
module resp_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      q      <= 1'b0;
    end else begin
      meta_q <= d;
      q      <= meta_q;
    end
  end

endmodule

// File: rtl/cell_exerciser.sv
// Sweeps every input vector of a combinational cell and checks its output
// against TRUTH. Define CELL_EXERCISER_RESP_SYNC_EN to synchronise resp.
module cell_exerciser
  import cell_exerciser_pkg::*;
#(
  parameter int unsigned                N_IN   = 2,
  parameter logic [vec_count(N_IN)-1:0] TRUTH  = 4'b0001,
  parameter int unsigned                SETTLE = 3
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  output logic [N_IN-1:0] stim,
  input  logic            resp,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [7:0]      err_count,
  output logic [N_IN-1:0] first_fail
);

  localparam int unsigned VEC_CNT = vec_count(N_IN);
  localparam logic [N_IN-1:0] VEC_MAX = N_IN'(VEC_CNT - 1);
`ifdef CELL_EXERCISER_RESP_SYNC_EN
  localparam int unsigned WAIT_CYC = SETTLE + 2;
`else
  localparam int unsigned WAIT_CYC = SETTLE;
`endif
  localparam int unsigned CNT_W    = 5;
  localparam int unsigned CNT_LOAD = (WAIT_CYC == 0) ? 0 : WAIT_CYC - 1;

  logic resp_s;

`ifdef CELL_EXERCISER_RESP_SYNC_EN
  resp_sync u_resp_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (resp),
    .q     (resp_s)
  );
`else
  assign resp_s = resp;
`endif

  state_e            state_q, state_d;
  logic [N_IN-1:0]   vec_q, vec_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_IN-1:0]   stim_q, stim_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              pass_q, pass_d;
  logic [7:0]        err_q, err_d;
  logic [N_IN-1:0]   ff_q, ff_d;
  logic              mismatch;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      vec_q   <= '0;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ff_q    <= '0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
    end
  end

  // Sweep sequencing; done follows the DONE state by one edge, alongside pass.
  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    cnt_d    = cnt_q;
    stim_d   = stim_q;
    pass_d   = pass_q;
    err_d    = err_q;
    ff_d     = ff_q;
    mismatch = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          err_d   = '0;
          ff_d    = '0;
          pass_d  = 1'b0;
          vec_d   = '0;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        stim_d  = vec_q;
        cnt_d   = CNT_W'(CNT_LOAD);
        state_d = (WAIT_CYC == 0) ? SAMPLE : WAIT;
      end
      WAIT: begin
        if (cnt_q == '0) state_d = SAMPLE;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      SAMPLE: begin
        mismatch = (resp_s != TRUTH[vec_q]);
        if (mismatch) begin
          if (err_q == '0)     ff_d  = vec_q;
          if (err_q != ERR_MAX) err_d = err_q + 8'd1;
        end
        if (vec_q == VEC_MAX) begin
          state_d = DONE;
        end else begin
          vec_d   = vec_q + N_IN'(1);
          state_d = DRIVE;
        end
      end
      DONE: begin
        pass_d  = (err_q == '0);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
    done_d = (state_q == DONE);
  end

  assign stim       = stim_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign pass       = pass_q;
  assign err_count  = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_cell_exerciser.sv
// Directed bench for cell_exerciser: NOR2 and NAND2 models with fault modes.
module tb_cell_exerciser;

`ifdef CELL_EXERCISER_RESP_SYNC_EN
  localparam int P_A     = 7;
  localparam int SWEEP_A = 29;
  localparam int SWEEP_B = 17;
`else
  localparam int P_A     = 5;
  localparam int SWEEP_A = 21;
  localparam int SWEEP_B = 9;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start_a = 1'b0;
  logic       start_b = 1'b0;
  logic [1:0] mode = 2'd0;

  logic [1:0] stim_a, ff_a, stim_b, ff_b;
  logic       resp_a, resp_b;
  logic       busy_a, done_a, pass_a, busy_b, done_b, pass_b;
  logic [7:0] err_a, err_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // mode 0: good NOR2, 1: output stuck at 0, 2: output stuck at 1
  assign resp_a = (mode == 2'd0) ? ~|stim_a : ((mode == 2'd1) ? 1'b0 : 1'b1);
  assign resp_b = ~&stim_b;

  cell_exerciser dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .stim(stim_a), .resp(resp_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a), .first_fail(ff_a)
  );

  cell_exerciser #(.N_IN(2), .TRUTH(4'b0111), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .stim(stim_b), .resp(resp_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b), .first_fail(ff_b)
  );

  // Pulse start_a and return the number of edges from the start edge to done.
  task automatic sweep_a(output int cyc);
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    cyc = 0;
    for (int k = 1; k <= 200; k++) begin
      if (done_a) begin
        cyc = k;
        break;
      end
      @(posedge clk); #1;
    end
    if (cyc != 0) cyc = cyc - 1;
  endtask

  task automatic test_reset();
    checks++; if (stim_a !== 2'd0) begin errors++; $display("FAIL reset_stim got %0d exp 0", stim_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy_a); end
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL reset_pass got %b exp 0", pass_a); end
    checks++; if (err_a !== 8'd0) begin errors++; $display("FAIL reset_err got %0d exp 0", err_a); end
    checks++; if (ff_a !== 2'd0) begin errors++; $display("FAIL reset_ff got %0d exp 0", ff_a); end
  endtask

  task automatic test_good();
    int cyc;
    mode = 2'd0;
    sweep_a(cyc);
    checks++; if (cyc != SWEEP_A) begin errors++; $display("FAIL good_latency got %0d exp %0d", cyc, SWEEP_A); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL good_pass got %b exp 1", pass_a); end
    checks++; if (err_a !== 8'd0) begin errors++; $display("FAIL good_err got %0d exp 0", err_a); end
    checks++; if (ff_a !== 2'd0) begin errors++; $display("FAIL good_ff got %0d exp 0", ff_a); end
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL good_busy got %b exp 0", busy_a); end
    checks++; if (stim_a !== 2'd3) begin errors++; $display("FAIL good_stim_hold got %0d exp 3", stim_a); end
    @(posedge clk); #1;
    checks++; if (done_a !== 1'b0) begin errors++; $display("FAIL good_done_pulse got %b exp 0", done_a); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL good_pass_hold got %b exp 1", pass_a); end
  endtask

  task automatic test_tied0();
    int cyc;
    mode = 2'd1;
    sweep_a(cyc);
    checks++; if (err_a !== 8'd1) begin errors++; $display("FAIL tied0_err got %0d exp 1", err_a); end
    checks++; if (ff_a !== 2'd0) begin errors++; $display("FAIL tied0_ff got %0d exp 0", ff_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL tied0_pass got %b exp 0", pass_a); end
  endtask

  task automatic test_tied1();
    int cyc;
    mode = 2'd2;
    sweep_a(cyc);
    checks++; if (err_a !== 8'd3) begin errors++; $display("FAIL tied1_err got %0d exp 3", err_a); end
    checks++; if (ff_a !== 2'd1) begin errors++; $display("FAIL tied1_ff got %0d exp 1", ff_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL tied1_pass got %b exp 0", pass_a); end
  endtask

  task automatic test_restart_ignored();
    int n_done = 0;
    int first = 0;
    mode = 2'd0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 1; k <= SWEEP_A + 10; k++) begin
      if (k == 5) start_a = 1'b1;
      @(posedge clk); #1 start_a = 1'b0;
      if (done_a) begin
        n_done++;
        if (first == 0) first = k;
      end
    end
    checks++; if (n_done != 1) begin errors++; $display("FAIL restart_done_count got %0d exp 1", n_done); end
    checks++; if (first != SWEEP_A) begin errors++; $display("FAIL restart_done_cycle got %0d exp %0d", first, SWEEP_A); end
    checks++; if (pass_a !== 1'b1) begin errors++; $display("FAIL restart_pass got %b exp 1", pass_a); end
  endtask

  task automatic test_reset_mid();
    int seen_done = 0;
    int cyc;
    mode = 2'd0;
    @(posedge clk); #1 start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 1; k <= 2 * P_A + 2; k++) begin
      @(posedge clk); #1;
    end
    checks++; if (stim_a !== 2'd2) begin errors++; $display("FAIL mid_stim_before got %0d exp 2", stim_a); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy_a !== 1'b0) begin errors++; $display("FAIL mid_busy got %b exp 0", busy_a); end
    checks++; if (stim_a !== 2'd0) begin errors++; $display("FAIL mid_stim got %0d exp 0", stim_a); end
    checks++; if (pass_a !== 1'b0) begin errors++; $display("FAIL mid_pass got %b exp 0", pass_a); end
    checks++; if (err_a !== 8'd0 || ff_a !== 2'd0) begin errors++; $display("FAIL mid_err_ff got %0d/%0d exp 0/0", err_a, ff_a); end
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      if (done_a) seen_done++;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int k = 0; k < SWEEP_A; k++) begin
      @(posedge clk); #1;
      if (done_a) seen_done++;
    end
    checks++; if (seen_done != 0) begin errors++; $display("FAIL mid_no_done got %0d exp 0", seen_done); end
    sweep_a(cyc);
    checks++; if (cyc != SWEEP_A) begin errors++; $display("FAIL mid_resweep_latency got %0d exp %0d", cyc, SWEEP_A); end
    checks++; if (pass_a !== 1'b1 || err_a !== 8'd0) begin errors++; $display("FAIL mid_resweep_result got pass %b err %0d exp 1/0", pass_a, err_a); end
  endtask

  task automatic test_nand_settle0();
    int cyc = 0;
    @(posedge clk); #1 start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    for (int k = 1; k <= 200; k++) begin
      if (done_b) begin
        cyc = k - 1;
        break;
      end
      @(posedge clk); #1;
    end
    checks++; if (cyc != SWEEP_B) begin errors++; $display("FAIL nand_latency got %0d exp %0d", cyc, SWEEP_B); end
    checks++; if (pass_b !== 1'b1) begin errors++; $display("FAIL nand_pass got %b exp 1", pass_b); end
    checks++; if (err_b !== 8'd0 || ff_b !== 2'd0) begin errors++; $display("FAIL nand_err_ff got %0d/%0d exp 0/0", err_b, ff_b); end
  endtask

  initial begin
    rst_n = 1'b0;
    #23;
    test_reset();
    @(negedge clk); rst_n = 1'b1;
    test_good();
    test_tied0();
    test_tied1();
    test_good();
    test_restart_ignored();
    test_reset_mid();
    test_nand_settle0();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
